npu_selftest_responder: RTL and testbench

//  Hardware responder to the simulation/host test runner. It accepts one test command at a time.
//  It launches the selected on-chip NPU self-test engine and watches it with a per-test cycle watchdog.
//  It returns a pass/fail/timeout response and keeps saturating run/pass/fail/timeout statistics.
//  It sits between the PCIe CSR command path and the NPU self-test engines.

---
 rtl/npu_selftest_responder_pkg.sv | 22 ++
 rtl/npu_selftest_responder_if.sv | 46 ++++
 rtl/npu_selftest_responder_sat_counter.sv | 26 ++
 rtl/npu_selftest_responder.sv | 130 +++++++++++++
 tb/tb_npu_selftest_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_selftest_responder_pkg.sv
// Shared types and default widths for the NPU self-test responder.
package npu_selftest_pkg;

  localparam int ID_W_DEF        = 6;
  localparam int TMO_W_DEF       = 20;
  localparam int CNT_W_DEF       = 16;
  localparam int DEF_TIMEOUT_DEF = 20000;

  typedef enum logic [1:0] {
    ST_PASS    = 2'b00,
    ST_FAIL    = 2'b01,
    ST_TIMEOUT = 2'b10
  } rsp_status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_REPORT
  } state_e;

endpackage

// File: rtl/npu_selftest_responder_if.sv
// Command, engine and response signals between the host test runner, the responder and the engines.
interface npu_selftest_responder_if
  import npu_selftest_pkg::*;
#(
  parameter int ID_W  = ID_W_DEF,
  parameter int TMO_W = TMO_W_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_clear;
  logic [ID_W-1:0]  cmd_id;
  logic [TMO_W-1:0] cmd_timeout;

  logic             eng_start;
  logic [ID_W-1:0]  eng_id;
  logic             eng_done;
  logic             eng_pass;
  logic             eng_abort;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [1:0]       rsp_status;
  logic [TMO_W-1:0] rsp_cycles;

  // The responder side.
  modport slave (
    input  cmd_valid, cmd_clear, cmd_id, cmd_timeout,
    output cmd_ready,
    output eng_start, eng_id, eng_abort,
    input  eng_done, eng_pass,
    output rsp_valid, rsp_id, rsp_status, rsp_cycles,
    input  rsp_ready
  );

  // The host runner plus engine side.
  modport master (
    output cmd_valid, cmd_clear, cmd_id, cmd_timeout,
    input  cmd_ready,
    input  eng_start, eng_id, eng_abort,
    output eng_done, eng_pass,
    input  rsp_valid, rsp_id, rsp_status, rsp_cycles,
    output rsp_ready
  );

endinterface

// File: rtl/npu_selftest_responder_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/npu_selftest_responder.sv
// Launches one NPU self-test at a time, guards it with a cycle watchdog and reports
// pass/fail/timeout with saturating statistics.
module npu_selftest_responder
  import npu_selftest_pkg::*;
#(
  parameter int ID_W        = ID_W_DEF,
  parameter int TMO_W       = TMO_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEF_TIMEOUT = DEF_TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  npu_selftest_responder_if.slave  bus,
  output logic [CNT_W-1:0]         stat_run,
  output logic [CNT_W-1:0]         stat_pass,
  output logic [CNT_W-1:0]         stat_fail,
  output logic [CNT_W-1:0]         stat_timeout,
  output logic                     spurious_done,
  output logic                     busy
);

  localparam logic [TMO_W-1:0] DEF_LIMIT = TMO_W'(DEF_TIMEOUT);

  state_e           state_q;
  logic             cmd_ready_q;
  logic [ID_W-1:0]  id_q;
  logic [TMO_W-1:0] limit_q;
  logic [TMO_W-1:0] cyc_q;
  rsp_status_e      rsp_status_q;
  logic [TMO_W-1:0] rsp_cycles_q;
  logic             rsp_valid_q;
  logic             eng_start_q;
  logic             spur_q;

  logic [TMO_W-1:0] limit_d;
  logic             accept;
  logic             stat_clr;
  logic             run_done;
  logic             run_tmo;

  assign accept   = (state_q == S_IDLE) && cmd_ready_q && bus.cmd_valid;
  assign stat_clr = accept && bus.cmd_clear;
  assign limit_d  = (bus.cmd_timeout == '0) ? DEF_LIMIT : bus.cmd_timeout;

  // Done beats the watchdog when both land in the same RUN cycle.
  assign run_done = (state_q == S_RUN) && bus.eng_done;
  assign run_tmo  = (state_q == S_RUN) && !bus.eng_done && (cyc_q == limit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      id_q         <= '0;
      limit_q      <= '0;
      cyc_q        <= '0;
      rsp_status_q <= ST_PASS;
      rsp_cycles_q <= '0;
      rsp_valid_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      spur_q       <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      if (stat_clr) spur_q <= 1'b0;
      if (bus.eng_done && (state_q != S_RUN)) spur_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept && !bus.cmd_clear) begin
            id_q        <= bus.cmd_id;
            limit_q     <= limit_d;
            cmd_ready_q <= 1'b0;
            eng_start_q <= 1'b1;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cyc_q   <= TMO_W'(1);
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (run_done || run_tmo) begin
            if (run_tmo)           rsp_status_q <= ST_TIMEOUT;
            else if (bus.eng_pass) rsp_status_q <= ST_PASS;
            else                   rsp_status_q <= ST_FAIL;
            rsp_cycles_q <= cyc_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_REPORT;
          end else begin
            cyc_q <= cyc_q + TMO_W'(1);
          end
        end
        S_REPORT: begin
          // Re-open the command port together with the return to IDLE.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_run (
    .clk(clk), .rst(rst), .clr_i(stat_clr), .inc_i(state_q == S_LAUNCH), .cnt_o(stat_run)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_pass (
    .clk(clk), .rst(rst), .clr_i(stat_clr), .inc_i(run_done && bus.eng_pass), .cnt_o(stat_pass)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_fail (
    .clk(clk), .rst(rst), .clr_i(stat_clr), .inc_i(run_done && !bus.eng_pass), .cnt_o(stat_fail)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_tmo (
    .clk(clk), .rst(rst), .clr_i(stat_clr), .inc_i(run_tmo), .cnt_o(stat_timeout)
  );

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.eng_id     = id_q;
  assign bus.eng_abort  = run_tmo;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_cycles = rsp_cycles_q;
  assign spurious_done  = spur_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_npu_selftest_responder.sv
// Randomized self-checking bench for npu_selftest_responder against a behavioural outcome model.
module tb_npu_selftest_responder;
  import npu_selftest_pkg::*;

  localparam int ID_W  = 6;
  localparam int TMO_W = 20;
  localparam int CNT_W = 4;
  localparam int DEFT  = 20000;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0] stat_run, stat_pass, stat_fail, stat_timeout;
  logic spurious_done, busy;

  int checks = 0;
  int failures = 0;
  int m_run = 0, m_pass = 0, m_fail = 0, m_tmo = 0;

  typedef struct {
    bit hung;
    bit start_ok;
    int abort_cnt;
    int abort_k;
    int rsp_k;
    logic [ID_W-1:0] r_id;
    logic [1:0] r_status;
    logic [TMO_W-1:0] r_cycles;
    bit stable_ok;
    bit post_ok;
  } obs_t;

  typedef struct {
    int status;
    int cycles;
    int abort_k;
  } exp_t;

  npu_selftest_responder_if #(.ID_W(ID_W), .TMO_W(TMO_W)) bus ();

  npu_selftest_responder #(
    .ID_W(ID_W), .TMO_W(TMO_W), .CNT_W(CNT_W), .DEF_TIMEOUT(DEFT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stat_run(stat_run), .stat_pass(stat_pass), .stat_fail(stat_fail),
    .stat_timeout(stat_timeout), .spurious_done(spurious_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Outcome of one test from the rules: done at or before the limit decides, otherwise timeout.
  function automatic exp_t model(input int tmo, input int done_k, input bit pass);
    exp_t e;
    int eff;
    eff = (tmo == 0) ? DEFT : tmo;
    if (done_k >= 1 && done_k <= eff) begin
      e.status = pass ? 0 : 1; e.cycles = done_k; e.abort_k = 0;
    end else begin
      e.status = 2; e.cycles = eff; e.abort_k = eff;
    end
    return e;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_account(input exp_t e);
    m_run = sat_inc(m_run);
    if (e.status == 0) m_pass = sat_inc(m_pass);
    else if (e.status == 1) m_fail = sat_inc(m_fail);
    else m_tmo = sat_inc(m_tmo);
  endtask

  // Drives one command and plays the engine; returns what was observed.
  task automatic run_cmd(input logic [ID_W-1:0] id, input int tmo, input int done_k,
                         input bit pass, input int rdy_dly, input bit hold_new, output obs_t o);
    int n;
    int bound;
    o = '{default: 0};
    o.stable_ok = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.cmd_ready !== 1'b1) begin o.hung = 1'b1; return; end
    bus.cmd_valid = 1'b1; bus.cmd_clear = 1'b0; bus.cmd_id = id; bus.cmd_timeout = TMO_W'(tmo);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    o.start_ok = (bus.eng_start === 1'b1) && (bus.eng_id === id) && (bus.cmd_ready === 1'b0);
    bound = ((tmo == 0) ? DEFT : tmo) + 5;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk); #1;
      bus.eng_done = 1'b0;
      if (bus.rsp_valid === 1'b1) begin o.rsp_k = k; break; end
      bus.eng_done = (k == done_k); bus.eng_pass = pass;
      #1;
      if (bus.eng_abort === 1'b1) begin o.abort_cnt++; o.abort_k = k; end
    end
    bus.eng_done = 1'b0;
    if (o.rsp_k == 0) begin o.hung = 1'b1; return; end
    o.r_id = bus.rsp_id; o.r_status = bus.rsp_status; o.r_cycles = bus.rsp_cycles;
    if (hold_new) begin
      bus.cmd_valid = 1'b1; bus.cmd_clear = 1'b0;
    end
    for (int d = 0; d < rdy_dly; d++) begin
      @(posedge clk); #1;
      if (bus.rsp_id !== o.r_id || bus.rsp_status !== o.r_status || bus.rsp_cycles !== o.r_cycles ||
          bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.eng_start !== 1'b0)
        o.stable_ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    o.post_ok = (bus.rsp_valid === 1'b0) && (bus.cmd_ready === 1'b1) && (busy === 1'b0);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({bus.cmd_ready, bus.eng_start, bus.eng_abort, bus.rsp_valid, busy, spurious_done} !== 6'b0 ||
        {stat_run, stat_pass, stat_fail, stat_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b start=%b abort=%b rvalid=%b busy=%b stats=%h, need all 0",
               bus.cmd_ready, bus.eng_start, bus.eng_abort, bus.rsp_valid, busy,
               {stat_run, stat_pass, stat_fail, stat_timeout});
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got ready=%b busy=%b, need 1/0", bus.cmd_ready, busy);
    end
  endtask

  task automatic test_pass;
    obs_t o;
    run_cmd(6'd5, 100, 10, 1'b1, 0, 1'b0, o);
    model_account(model(100, 10, 1'b1));
    checks++;
    if (o.hung || !o.start_ok || o.rsp_k != 11) begin
      failures++;
      $display("FAIL pass_timing: got hung=%0d start_ok=%0d rsp_k=%0d, need 0/1/11", o.hung, o.start_ok, o.rsp_k);
    end
    checks++;
    if (o.r_id !== 6'd5 || o.r_status !== 2'b00 || o.r_cycles !== 20'd10 || o.abort_cnt != 0) begin
      failures++;
      $display("FAIL pass_resp: got id=%0d st=%0d cyc=%0d aborts=%0d, need 5/0/10/0",
               o.r_id, o.r_status, o.r_cycles, o.abort_cnt);
    end
    checks++;
    if (stat_run !== CNT_W'(1) || stat_pass !== CNT_W'(1)) begin
      failures++;
      $display("FAIL pass_stats: got run=%0d pass=%0d, need 1/1", stat_run, stat_pass);
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_cmd(6'd3, 4, 0, 1'b0, 1, 1'b0, o);
    model_account(model(4, 0, 1'b0));
    checks++;
    if (o.hung || o.abort_cnt != 1 || o.abort_k != 4) begin
      failures++;
      $display("FAIL timeout_abort: got hung=%0d aborts=%0d at %0d, need 1 at RUN cycle 4", o.hung, o.abort_cnt, o.abort_k);
    end
    checks++;
    if (o.r_id !== 6'd3 || o.r_status !== 2'b10 || o.r_cycles !== 20'd4 || stat_timeout !== CNT_W'(m_tmo)) begin
      failures++;
      $display("FAIL timeout_resp: got id=%0d st=%0d cyc=%0d stmo=%0d, need 3/2/4/%0d",
               o.r_id, o.r_status, o.r_cycles, stat_timeout, m_tmo);
    end
  endtask

  task automatic test_tie;
    obs_t o;
    run_cmd(6'd9, 4, 4, 1'b0, 0, 1'b0, o);
    model_account(model(4, 4, 1'b0));
    checks++;
    if (o.hung || o.r_status !== 2'b01 || o.abort_cnt != 0 || o.r_cycles !== 20'd4) begin
      failures++;
      $display("FAIL tie_done_wins: got st=%0d aborts=%0d cyc=%0d, need 1/0/4", o.r_status, o.abort_cnt, o.r_cycles);
    end
    checks++;
    if ({stat_run, stat_pass, stat_fail, stat_timeout} !==
        {CNT_W'(m_run), CNT_W'(m_pass), CNT_W'(m_fail), CNT_W'(m_tmo)}) begin
      failures++;
      $display("FAIL tie_stats: got %0d/%0d/%0d/%0d, need %0d/%0d/%0d/%0d", stat_run, stat_pass,
               stat_fail, stat_timeout, m_run, m_pass, m_fail, m_tmo);
    end
  endtask

  task automatic test_limit_one;
    obs_t o;
    run_cmd(6'd1, 1, 0, 1'b0, 0, 1'b0, o);
    model_account(model(1, 0, 1'b0));
    checks++;
    if (o.hung || o.r_status !== 2'b10 || o.r_cycles !== 20'd1 || o.abort_k != 1 || o.rsp_k != 2) begin
      failures++;
      $display("FAIL limit_one: got st=%0d cyc=%0d abort_k=%0d rsp_k=%0d, need 2/1/1/2",
               o.r_status, o.r_cycles, o.abort_k, o.rsp_k);
    end
    run_cmd(6'd2, 50, 1, 1'b1, 0, 1'b0, o);
    model_account(model(50, 1, 1'b1));
    checks++;
    if (o.hung || o.rsp_k != 2 || o.r_cycles !== 20'd1 || o.r_status !== 2'b00) begin
      failures++;
      $display("FAIL first_cycle_done: got rsp_k=%0d cyc=%0d st=%0d, need 2/1/0", o.rsp_k, o.r_cycles, o.r_status);
    end
  endtask

  task automatic test_backpressure;
    obs_t o;
    run_cmd(6'd7, 30, 3, 1'b1, 20, 1'b1, o);
    model_account(model(30, 3, 1'b1));
    checks++;
    if (o.hung || !o.stable_ok || !o.post_ok) begin
      failures++;
      $display("FAIL backpressure_hold: got hung=%0d stable=%0d post=%0d, need 0/1/1", o.hung, o.stable_ok, o.post_ok);
    end
    run_cmd(6'd8, 30, 2, 1'b0, 0, 1'b0, o);
    model_account(model(30, 2, 1'b0));
    checks++;
    if (o.hung || !o.start_ok || o.r_id !== 6'd8 || o.r_status !== 2'b01) begin
      failures++;
      $display("FAIL backpressure_next: got start_ok=%0d id=%0d st=%0d, need 1/8/1", o.start_ok, o.r_id, o.r_status);
    end
  endtask

  task automatic test_random;
    obs_t o;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      logic [ID_W-1:0] id;
      int tmo, dk, rd;
      bit ps;
      id = ID_W'($urandom_range(0, 63));
      tmo = $urandom_range(1, 12);
      dk = $urandom_range(0, 14);
      ps = 1'($urandom_range(0, 1));
      rd = $urandom_range(0, 3);
      run_cmd(id, tmo, dk, ps, rd, 1'b0, o);
      e = model(tmo, dk, ps);
      model_account(e);
      checks++;
      if (o.hung || !o.start_ok || !o.stable_ok || !o.post_ok || o.r_id !== id ||
          o.r_status !== 2'(e.status) || o.r_cycles !== TMO_W'(e.cycles) ||
          o.abort_k != e.abort_k || o.rsp_k != e.cycles + 1) begin
        failures++;
        $display("FAIL random_%0d: tmo=%0d done_k=%0d got id=%0d st=%0d cyc=%0d abort_k=%0d rsp_k=%0d, need id=%0d st=%0d cyc=%0d abort_k=%0d rsp_k=%0d",
                 i, tmo, dk, o.r_id, o.r_status, o.r_cycles, o.abort_k, o.rsp_k,
                 id, e.status, e.cycles, e.abort_k, e.cycles + 1);
      end
      checks++;
      if ({stat_run, stat_pass, stat_fail, stat_timeout} !==
          {CNT_W'(m_run), CNT_W'(m_pass), CNT_W'(m_fail), CNT_W'(m_tmo)}) begin
        failures++;
        $display("FAIL random_stats_%0d: got %0d/%0d/%0d/%0d, need %0d/%0d/%0d/%0d", i, stat_run,
                 stat_pass, stat_fail, stat_timeout, m_run, m_pass, m_fail, m_tmo);
      end
    end
  endtask

  task automatic test_default;
    obs_t o;
    run_cmd(6'd11, 0, 0, 1'b0, 0, 1'b0, o);
    model_account(model(0, 0, 1'b0));
    checks++;
    if (o.hung || o.r_status !== 2'b10 || o.r_cycles !== TMO_W'(DEFT) || o.abort_k != DEFT || o.abort_cnt != 1) begin
      failures++;
      $display("FAIL default_timeout: got hung=%0d st=%0d cyc=%0d abort_k=%0d, need 0/2/%0d/%0d",
               o.hung, o.r_status, o.r_cycles, o.abort_k, DEFT, DEFT);
    end
  endtask

  task automatic test_clear;
    bit seen;
    bus.cmd_valid = 1'b1; bus.cmd_clear = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_clear = 1'b0;
    m_run = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.eng_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if ({stat_run, stat_pass, stat_fail, stat_timeout} !== '0 || seen || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_stats: got stats=%h activity=%0d ready=%b, need 0/0/1",
               {stat_run, stat_pass, stat_fail, stat_timeout}, seen, bus.cmd_ready);
    end
  endtask

  task automatic test_saturation;
    obs_t o;
    for (int i = 0; i < CMAX + 5; i++) begin
      run_cmd(ID_W'(i), 8, $urandom_range(1, 3), 1'b1, 0, 1'b0, o);
      model_account(model(8, 1, 1'b1));
    end
    checks++;
    if (stat_pass !== CNT_W'(CMAX) || stat_run !== CNT_W'(CMAX) || m_pass != CMAX) begin
      failures++;
      $display("FAIL saturation: got pass=%0d run=%0d, need %0d/%0d", stat_pass, stat_run, CMAX, CMAX);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    bus.cmd_valid = 1'b1; bus.cmd_id = 6'd21; bus.cmd_timeout = 20'd3;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_setup: got busy=%b, need 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.eng_abort, bus.eng_start, bus.rsp_valid, bus.cmd_ready, busy} !== 5'b0 ||
        {stat_run, stat_pass, stat_fail, stat_timeout} !== '0 || bus.eng_id !== '0) begin
      failures++;
      $display("FAIL reset_mid: got abort=%b start=%b rvalid=%b busy=%b stats=%h, need all 0",
               bus.eng_abort, bus.eng_start, bus.rsp_valid, busy, {stat_run, stat_pass, stat_fail, stat_timeout});
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.eng_abort !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_abort: got abort=%b, need 0", bus.eng_abort);
      end
    end
    rst = 1'b0;
    m_run = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_spurious;
    obs_t o;
    run_cmd(6'd4, 10, 2, 1'b1, 0, 1'b0, o);
    model_account(model(10, 2, 1'b1));
    checks++;
    if (spurious_done !== 1'b0) begin
      failures++;
      $display("FAIL spurious_idle_clean: got %b, need 0", spurious_done);
    end
    bus.eng_done = 1'b1; bus.eng_pass = 1'b1;
    @(posedge clk); #1;
    bus.eng_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (spurious_done !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        {stat_run, stat_pass, stat_fail, stat_timeout} !==
        {CNT_W'(m_run), CNT_W'(m_pass), CNT_W'(m_fail), CNT_W'(m_tmo)}) begin
      failures++;
      $display("FAIL spurious_set: got spur=%b busy=%b rvalid=%b run=%0d pass=%0d, need 1/0/0/%0d/%0d",
               spurious_done, busy, bus.rsp_valid, stat_run, stat_pass, m_run, m_pass);
    end
    bus.cmd_valid = 1'b1; bus.cmd_clear = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_clear = 1'b0;
    checks++;
    if (spurious_done !== 1'b0 || stat_run !== '0) begin
      failures++;
      $display("FAIL spurious_clear: got spur=%b run=%0d, need 0/0", spurious_done, stat_run);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_clear = 1'b0; bus.cmd_id = '0; bus.cmd_timeout = '0;
    bus.eng_done = 1'b0; bus.eng_pass = 1'b0; bus.rsp_ready = 1'b0;
    test_reset();
    test_pass();
    test_timeout();
    test_tie();
    test_limit_one();
    test_backpressure();
    test_random();
    test_default();
    test_clear();
    test_saturation();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
